// File: rtl/hough_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hough_pkg
// Brief    : Shared widths, theta stepping and bin clamping for the rho sweep.
// Revision : 1.0
// ============================================================================
package hough_pkg;

    typedef struct packed {
        logic        clip;
        logic [31:0] bin;
    } clamp_t;

    function automatic int trig_frac(input int trig_w);
        return trig_w - 2;
    endfunction

    function automatic int prod_w(input int coord_w, input int trig_w);
        return coord_w + trig_w + 1;
    endfunction

    function automatic int sum_w(input int coord_w, input int trig_w);
        return coord_w + trig_w + 2;
    endfunction

    function automatic int unsigned theta_inc(input int unsigned idx, input int unsigned n);
        return (idx >= n - 1) ? 32'd0 : idx + 32'd1;
    endfunction

    function automatic int unsigned theta_mod(input int unsigned v, input int unsigned n);
        return v % n;
    endfunction

    // Saturates a signed bin index into [0, 2^bin_w-1].
    function automatic clamp_t clamp_bin(input longint v, input int bin_w);
        clamp_t r;
        longint max_v;
        max_v  = (longint'(1) <<< bin_w) - longint'(1);
        r.clip = 1'b0;
        r.bin  = v[31:0];
        if (v < 0) begin
            r.clip = 1'b1;
            r.bin  = '0;
        end else if (v > max_v) begin
            r.clip = 1'b1;
            r.bin  = max_v[31:0];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rho_sweep_engine_trig_rom.sv
`default_nettype none
// ============================================================================
// Module   : trig_rom
// Brief    : Synchronous signed cos/sin table over [0, pi), built at elaboration.
// Revision : 1.0
// ============================================================================
module trig_rom #(
    parameter int N_THETA = 180,
    parameter int TRIG_W  = 18,
    parameter int THETA_W = 8
) (
    input  logic                      clk,
    input  logic                      rd_en,
    input  logic [THETA_W-1:0]        addr,
    output logic signed [TRIG_W-1:0]  cos_q,
    output logic signed [TRIG_W-1:0]  sin_q
);
    localparam int  c_depth = 2 ** THETA_W;
    localparam int  c_one   = 1 << (TRIG_W - 2);
    localparam real c_pi    = 3.14159265358979323846;

    function automatic int round_q(input real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction

    logic signed [TRIG_W-1:0] w_cos_tab [c_depth];
    logic signed [TRIG_W-1:0] w_sin_tab [c_depth];

    // Table padded to a power of two so any address is in range.
    for (genvar i = 0; i < c_depth; i++) begin : g_entry
        if (i < N_THETA) begin : g_angle
            localparam real c_ang   = c_pi * i / N_THETA;
            localparam int  c_cos_i = round_q($cos(c_ang) * c_one);
            localparam int  c_sin_i = round_q($sin(c_ang) * c_one);
            assign w_cos_tab[i] = c_cos_i[TRIG_W-1:0];
            assign w_sin_tab[i] = c_sin_i[TRIG_W-1:0];
        end else begin : g_pad
            assign w_cos_tab[i] = '0;
            assign w_sin_tab[i] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            cos_q <= w_cos_tab[addr];
            sin_q <= w_sin_tab[addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/rho_sweep_engine.sv
`default_nettype none
// ============================================================================
// Module   : rho_sweep_engine
// Brief    : Sweeps a theta window per edge pixel, emitting (theta, rho_bin).
// Revision : 1.0
// ============================================================================
module rho_sweep_engine
    import hough_pkg::*;
#(
    parameter int COORD_W    = 12,
    parameter int TRIG_W     = 18,
    parameter int N_THETA    = 180,
    parameter int THETA_W    = 8,
    parameter int RHO_BIN_W  = 12,
    parameter int RHO_OFFSET = 2048
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic [THETA_W-1:0]   cfg_theta_start,
    input  logic [THETA_W-1:0]   cfg_theta_end,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [COORD_W-1:0]   in_x,
    input  logic [COORD_W-1:0]   in_y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [THETA_W-1:0]   out_theta,
    output logic [RHO_BIN_W-1:0] out_rho_bin,
    output logic                 out_last,
    output logic                 out_clip
);
    localparam int c_trig_frac = trig_frac(TRIG_W);
    localparam int c_prod_w    = prod_w(COORD_W, TRIG_W);
    localparam int c_sum_w     = sum_w(COORD_W, TRIG_W);
    localparam logic signed [c_sum_w-1:0] c_round = c_sum_w'(longint'(1) <<< (TRIG_W - 3));

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_sweep = 1'b1;

    logic [0:0]         r_state;
    logic [COORD_W-1:0] r_x, r_y;
    logic [THETA_W-1:0] r_idx, r_end;

    logic r_s1_valid, r_s1_last, r_s2_valid, r_s2_last, r_s3_valid, r_s3_last;
    logic [THETA_W-1:0] r_s1_theta, r_s2_theta, r_s3_theta;
    logic [COORD_W-1:0] r_s1_x, r_s1_y;
    logic signed [c_prod_w-1:0] r_s2_pxc, r_s2_pys;
    logic signed [c_sum_w-1:0]  r_s3_rho;

    logic                 r_out_valid, r_out_last, r_out_clip;
    logic [THETA_W-1:0]   r_out_theta;
    logic [RHO_BIN_W-1:0] r_out_rho_bin;

    logic w_en, w_last_issue, w_issue, w_accept;
    logic signed [TRIG_W-1:0]   w_cos, w_sin;
    logic signed [c_prod_w-1:0] w_x_ext, w_y_ext, w_cos_ext, w_sin_ext;
    logic signed [c_sum_w-1:0]  w_sum;
    clamp_t                     w_clamp;

    // Whole pipeline advances together; a stalled output freezes everything.
    assign w_en         = out_ready | ~r_out_valid;
    assign w_last_issue = (r_state == c_st_sweep) && (r_idx == r_end);
    assign w_issue      = (r_state == c_st_sweep) && w_en;
    assign in_ready     = w_en && ((r_state == c_st_idle) || w_last_issue);
    assign w_accept     = in_valid && in_ready;

    trig_rom #(
        .N_THETA (N_THETA),
        .TRIG_W  (TRIG_W),
        .THETA_W (THETA_W)
    ) u_trig_rom (
        .clk   (clk),
        .rd_en (w_en),
        .addr  (r_idx),
        .cos_q (w_cos),
        .sin_q (w_sin)
    );

    assign w_x_ext   = c_prod_w'($signed({1'b0, r_s1_x}));
    assign w_y_ext   = c_prod_w'($signed({1'b0, r_s1_y}));
    assign w_cos_ext = c_prod_w'(w_cos);
    assign w_sin_ext = c_prod_w'(w_sin);
    assign w_sum     = c_sum_w'(r_s2_pxc) + c_sum_w'(r_s2_pys) + c_round;
    assign w_clamp   = clamp_bin(longint'(r_s3_rho) + longint'(RHO_OFFSET), RHO_BIN_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_x     <= '0;
            r_y     <= '0;
            r_idx   <= '0;
            r_end   <= '0;
        end else if (clr) begin
            r_state <= c_st_idle;
            r_x     <= '0;
            r_y     <= '0;
            r_idx   <= '0;
            r_end   <= '0;
        end else if (w_en) begin
            if (w_accept) begin
                r_state <= c_st_sweep;
                r_x     <= in_x;
                r_y     <= in_y;
                r_idx   <= THETA_W'(theta_mod(32'(cfg_theta_start), N_THETA));
                r_end   <= THETA_W'(theta_mod(32'(cfg_theta_end), N_THETA));
            end else if (w_last_issue) begin
                r_state <= c_st_idle;
            end else if (r_state == c_st_sweep) begin
                r_idx   <= THETA_W'(theta_inc(32'(r_idx), N_THETA));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0; r_s1_last <= 1'b0; r_s1_theta <= '0; r_s1_x <= '0; r_s1_y <= '0;
            r_s2_valid <= 1'b0; r_s2_last <= 1'b0; r_s2_theta <= '0; r_s2_pxc <= '0; r_s2_pys <= '0;
            r_s3_valid <= 1'b0; r_s3_last <= 1'b0; r_s3_theta <= '0; r_s3_rho <= '0;
            r_out_valid <= 1'b0; r_out_last <= 1'b0; r_out_clip <= 1'b0;
            r_out_theta <= '0; r_out_rho_bin <= '0;
        end else if (clr) begin
            r_s1_valid <= 1'b0; r_s1_last <= 1'b0; r_s1_theta <= '0; r_s1_x <= '0; r_s1_y <= '0;
            r_s2_valid <= 1'b0; r_s2_last <= 1'b0; r_s2_theta <= '0; r_s2_pxc <= '0; r_s2_pys <= '0;
            r_s3_valid <= 1'b0; r_s3_last <= 1'b0; r_s3_theta <= '0; r_s3_rho <= '0;
            r_out_valid <= 1'b0; r_out_last <= 1'b0; r_out_clip <= 1'b0;
            r_out_theta <= '0; r_out_rho_bin <= '0;
        end else if (w_en) begin
            // Coordinates travel with the ROM read so a reload cannot corrupt it.
            r_s1_valid    <= w_issue;
            r_s1_last     <= w_last_issue;
            r_s1_theta    <= r_idx;
            r_s1_x        <= r_x;
            r_s1_y        <= r_y;
            r_s2_valid    <= r_s1_valid;
            r_s2_last     <= r_s1_last;
            r_s2_theta    <= r_s1_theta;
            r_s2_pxc      <= w_x_ext * w_cos_ext;
            r_s2_pys      <= w_y_ext * w_sin_ext;
            r_s3_valid    <= r_s2_valid;
            r_s3_last     <= r_s2_last;
            r_s3_theta    <= r_s2_theta;
            r_s3_rho      <= w_sum >>> c_trig_frac;
            r_out_valid   <= r_s3_valid;
            r_out_last    <= r_s3_last;
            r_out_theta   <= r_s3_theta;
            r_out_clip    <= w_clamp.clip;
            r_out_rho_bin <= RHO_BIN_W'(w_clamp.bin);
        end
    end

    assign out_valid   = r_out_valid;
    assign out_last    = r_out_last;
    assign out_clip    = r_out_clip;
    assign out_theta   = r_out_theta;
    assign out_rho_bin = r_out_rho_bin;

endmodule
`default_nettype wire
